secp256k1_jacobian_to_affine: RTL and testbench
===============================================

# secp256k1_jacobian_to_affine

- Converts a secp256k1 point from Jacobian (X, Y, Z) to affine (x, y): x = X·Z⁻², y = Y·Z⁻³ mod p.
- Z⁻¹ is computed by Fermat inversion, Z^(p−2), with MSB-first square-and-multiply on one shared modular multiplier.
- Sits directly downstream of `secp256k1_point_double` (and the point adder). It consumes their (x3, y3, z3) after `done` and produces final affine coordinates for comparison and hashing.

## Interface
Parameters: none. p and p−2 come from the shared package.

- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request conversion. Sampled only in IDLE.
- `x_in`, `y_in`, `z_in` input 256 each: Jacobian coordinates. Each must be < p; results for unreduced inputs are undefined.
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: single-cycle pulse; results are valid in that cycle.
- `x_out`, `y_out` output 256 each: affine result. Held until the next `done`.
- `infinity` output 1: set with `done` when z_in = 0. Held until the next `done`.

## Operation
- Reset: `busy`, `done` and `infinity` = 0. `x_out`, `y_out` and all internal registers = 0. State = IDLE.
- IDLE, with `start` = 1:
  - Latch x_in, y_in and z_in into X, Y and Z. Upstream may change its inputs afterwards.
  - If Z = 0, go to INF. Otherwise go to INV_INIT.
- INF: `x_out` = `y_out` = 0, `infinity` = 1, then go to DONE. No multiplier transaction is issued.
- INV_INIT:
  - acc ← Z (bit 255 of p−2 is 1).
  - Bit counter i ← 254.
  - Issue acc·acc, then go to INV_SQR.
- INV_SQR, on `mul_done`:
  - acc ← result.
  - If bit i of p−2 = 1, issue acc·Z and go to INV_MUL.
  - Otherwise, if i = 0, go to ZINV2. Else decrement i and issue the next square.
- INV_MUL, on `mul_done`:
  - acc ← result.
  - If i = 0, go to ZINV2. Else decrement i, issue a square and go to INV_SQR.
- The counter must never wrap from 0 to 255; leaving the loop at i = 0 is the only exit.
- After the loop, run this fixed tail, one multiplier transaction per state, in order:
  - ZINV2: t = zinv².
  - XAFF: x_out = X·t.
  - ZINV3: t = t·zinv.
  - YAFF: y_out = Y·t.
  - Then go to DONE.
- DONE: `done` = 1 for one cycle, `infinity` = 0 on the non-infinite path, then go to IDLE.
- A `start` received while busy is ignored. It is not queued.
- Reset mid-operation aborts immediately, returns to the reset values and resets the multiplier instance. No `done` pulse is produced.

## Timing
- Each multiplier transaction costs L+1 cycles, where L is the `secp256k1_mul_mod` start-to-done latency. `mul_start` is registered one cycle after the preceding `mul_done` or state entry.
- Popcount of p−2 is 249, so the loop issues 255 squares plus 248 multiplies = 503 transactions. The tail adds 4, for exactly 507 transactions.
- Non-infinite path: `done` occurs 507·(L+1) + 2 cycles after `start` is sampled.
- Z = 0 path: `done` occurs 2 cycles after `start` is sampled.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that cycle.

## Structure
- The shared package `secp256k1_pkg` holds `SECP256K1_P`, `SECP256K1_P_MINUS_2` (…FFFEFFFFFC2D) and the state enum width.
- One sub-module: a single instance of the existing `secp256k1_mul_mod` (start/done handshake).
- No add_mod or sub_mod instances.
- The exponent is a constant. The bit select uses the counter; no shift register.

## Test plan
- **G with Z = 1:** X = Gx = 79BE667E…16F81798, Y = Gy = 483ADA77…FB10D4B8, Z = 1.
  - Expect x_out = Gx, y_out = Gy, `infinity` = 0.
  - Expect exactly 507 `mul_start` pulses and latency 507·(L+1) + 2.
- **G scaled by Z = 2:** X = 4·Gx mod p, Y = 8·Gy mod p, Z = 2.
  - Expect x_out = Gx, y_out = Gy.
- **Chained with secp256k1_point_double on (Gx, Gy, 1):**
  - Expect x_out = C6047F94…5C709EE5 and y_out = 1AE168FE…50CFE52A (2G).
- **Z = 0:**
  - Expect `done` 2 cycles after `start`, x_out = y_out = 0, `infinity` = 1.
  - Expect no `mul_start`.
- **Start during busy:** pulse `start` with different inputs at transaction 100.
  - Expect it to be ignored, the original result returned, and a single `done`.
- **Reset mid-run:** deassert `rst_n` during the loop at i ≈ 128.
  - Expect all outputs 0 and no `done`.
  - Expect a subsequent G conversion to complete correctly.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 constants, FSM state encoding and the field reduction helper.
package secp256k1_pkg;

    // Field prime p = 2^256 - 2^32 - 977 and the Fermat inversion exponent p - 2.
    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] SECP256K1_P_MINUS_2 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    // 2^256 mod p, used to fold the high half of a product back into the low half.
    localparam logic [32:0] SECP256K1_C = 33'h1_000003D1;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_INF      = 4'd1,
        ST_INV_INIT = 4'd2,
        ST_INV_SQR  = 4'd3,
        ST_INV_MUL  = 4'd4,
        ST_ZINV2    = 4'd5,
        ST_XAFF     = 4'd6,
        ST_ZINV3    = 4'd7,
        ST_YAFF     = 4'd8,
        ST_DONE     = 4'd9
    } j2a_state_e;

    // Reduce a 512-bit product (< p^2) modulo p using two folds of 2^256 = C,
    // after which a single conditional subtraction is enough.
    function automatic logic [255:0] secp256k1_reduce(input logic [511:0] v);
        logic [289:0] f1;
        logic [256:0] f2;
        logic [256:0] f2_sub;
        f1 = {34'd0, v[255:0]} + ({34'd0, v[511:256]} * {257'd0, SECP256K1_C});
        f2 = {1'b0, f1[255:0]} + ({223'd0, f1[289:256]} * {224'd0, SECP256K1_C});
        f2_sub = f2 - {1'b0, SECP256K1_P};
        return (f2 >= {1'b0, SECP256K1_P}) ? f2_sub[255:0] : f2[255:0];
    endfunction

endpackage

// File: rtl/secp256k1_jacobian_to_affine_if.sv
// Request/result bundle between the point arithmetic stage and the affine converter.
interface secp256k1_jacobian_to_affine_if;
    logic         start;
    logic [255:0] x_in;
    logic [255:0] y_in;
    logic [255:0] z_in;
    logic         busy;
    logic         done;
    logic [255:0] x_out;
    logic [255:0] y_out;
    logic         infinity;

    modport master (
        output start, x_in, y_in, z_in,
        input  busy, done, x_out, y_out, infinity
    );

    modport slave (
        input  start, x_in, y_in, z_in,
        output busy, done, x_out, y_out, infinity
    );
endinterface

// File: rtl/secp256k1_mul_mod.sv
// Modular multiplier mod p: full product in the first stage, fold-and-reduce in the
// second. done pulses two cycles after start with the reduced result.
module secp256k1_mul_mod
    import secp256k1_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         done,
    output logic [255:0] result
);

    logic [511:0] prod_r;
    logic         prod_vld_r;
    logic         done_r;
    logic [255:0] result_r;

    // Stage 1: capture the full 512-bit product when a transaction starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r     <= 512'd0;
            prod_vld_r <= 1'b0;
        end else begin
            prod_vld_r <= start;
            if (start) begin
                prod_r <= {256'd0, a} * {256'd0, b};
            end
        end
    end

    // Stage 2: reduce modulo p and raise done for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= 256'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= prod_vld_r;
            if (prod_vld_r) begin
                result_r <= secp256k1_reduce(prod_r);
            end
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: rtl/secp256k1_jacobian_to_affine.sv
// Jacobian (X, Y, Z) to affine (x, y) conversion for secp256k1. Z^-1 is formed by
// Fermat inversion Z^(p-2) with MSB-first square-and-multiply on one shared multiplier,
// followed by a fixed four-multiply tail producing X*Z^-2 and Y*Z^-3.
module secp256k1_jacobian_to_affine (
    input  logic                                clk,
    input  logic                                rst_n,
    secp256k1_jacobian_to_affine_if.slave       bus
);
    import secp256k1_pkg::*;

    j2a_state_e   state_r;
    j2a_state_e   state_nx_s;

    logic [255:0] x_r;
    logic [255:0] y_r;
    logic [255:0] z_r;
    logic [255:0] acc_r;
    logic [255:0] t_r;
    logic [255:0] xa_r;
    logic [7:0]   bit_r;

    logic         mul_start_r;
    logic [255:0] mul_a_r;
    logic [255:0] mul_b_r;
    logic         mul_done_s;
    logic [255:0] mul_res_s;

    logic         busy_r;
    logic         done_r;
    logic         inf_r;
    logic [255:0] x_out_r;
    logic [255:0] y_out_r;

    logic         exp_bit_s;
    logic         issue_s;
    logic [255:0] op_a_s;
    logic [255:0] op_b_s;
    logic         latch_s;
    logic         acc_ld_s;
    logic [255:0] acc_nx_s;
    logic         bit_ld_s;
    logic [7:0]   bit_nx_s;
    logic         t_ld_s;
    logic         xa_ld_s;
    logic         out_ld_s;
    logic [255:0] out_x_s;
    logic [255:0] out_y_s;
    logic         out_inf_s;

    // The exponent is constant; the loop counter selects the current bit directly.
    assign exp_bit_s = SECP256K1_P_MINUS_2[bit_r];

    secp256k1_mul_mod u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_r),
        .a      (mul_a_r),
        .b      (mul_b_r),
        .done   (mul_done_s),
        .result (mul_res_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic, multiplier issue and datapath load decisions.
    always_comb begin
        state_nx_s = state_r;
        issue_s    = 1'b0;
        op_a_s     = 256'd0;
        op_b_s     = 256'd0;
        latch_s    = 1'b0;
        acc_ld_s   = 1'b0;
        acc_nx_s   = 256'd0;
        bit_ld_s   = 1'b0;
        bit_nx_s   = 8'd0;
        t_ld_s     = 1'b0;
        xa_ld_s    = 1'b0;
        out_ld_s   = 1'b0;
        out_x_s    = 256'd0;
        out_y_s    = 256'd0;
        out_inf_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    latch_s = 1'b1;
                    if (bus.z_in == 256'd0) begin
                        state_nx_s = ST_INF;
                    end else begin
                        state_nx_s = ST_INV_INIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_INF: begin
                // Point at infinity: zero coordinates, no multiplier traffic.
                out_ld_s   = 1'b1;
                out_inf_s  = 1'b1;
                state_nx_s = ST_DONE;
            end
            ST_INV_INIT: begin
                // Top exponent bit is 1, so the accumulator starts at Z.
                acc_ld_s   = 1'b1;
                acc_nx_s   = z_r;
                bit_ld_s   = 1'b1;
                bit_nx_s   = 8'd254;
                issue_s    = 1'b1;
                op_a_s     = z_r;
                op_b_s     = z_r;
                state_nx_s = ST_INV_SQR;
            end
            ST_INV_SQR: begin
                if (mul_done_s) begin
                    acc_ld_s = 1'b1;
                    acc_nx_s = mul_res_s;
                    issue_s  = 1'b1;
                    if (exp_bit_s) begin
                        op_a_s     = mul_res_s;
                        op_b_s     = z_r;
                        state_nx_s = ST_INV_MUL;
                    end else if (bit_r == 8'd0) begin
                        op_a_s     = mul_res_s;
                        op_b_s     = mul_res_s;
                        state_nx_s = ST_ZINV2;
                    end else begin
                        bit_ld_s   = 1'b1;
                        bit_nx_s   = bit_r - 8'd1;
                        op_a_s     = mul_res_s;
                        op_b_s     = mul_res_s;
                        state_nx_s = ST_INV_SQR;
                    end
                end else begin
                    state_nx_s = ST_INV_SQR;
                end
            end
            ST_INV_MUL: begin
                if (mul_done_s) begin
                    acc_ld_s = 1'b1;
                    acc_nx_s = mul_res_s;
                    issue_s  = 1'b1;
                    op_a_s   = mul_res_s;
                    op_b_s   = mul_res_s;
                    if (bit_r == 8'd0) begin
                        state_nx_s = ST_ZINV2;
                    end else begin
                        bit_ld_s   = 1'b1;
                        bit_nx_s   = bit_r - 8'd1;
                        state_nx_s = ST_INV_SQR;
                    end
                end else begin
                    state_nx_s = ST_INV_MUL;
                end
            end
            ST_ZINV2: begin
                // t = zinv^2 arrives; start X * t.
                if (mul_done_s) begin
                    t_ld_s     = 1'b1;
                    issue_s    = 1'b1;
                    op_a_s     = x_r;
                    op_b_s     = mul_res_s;
                    state_nx_s = ST_XAFF;
                end else begin
                    state_nx_s = ST_ZINV2;
                end
            end
            ST_XAFF: begin
                // Affine x arrives; start t * zinv for zinv^3.
                if (mul_done_s) begin
                    xa_ld_s    = 1'b1;
                    issue_s    = 1'b1;
                    op_a_s     = t_r;
                    op_b_s     = acc_r;
                    state_nx_s = ST_ZINV3;
                end else begin
                    state_nx_s = ST_XAFF;
                end
            end
            ST_ZINV3: begin
                if (mul_done_s) begin
                    t_ld_s     = 1'b1;
                    issue_s    = 1'b1;
                    op_a_s     = y_r;
                    op_b_s     = mul_res_s;
                    state_nx_s = ST_YAFF;
                end else begin
                    state_nx_s = ST_ZINV3;
                end
            end
            ST_YAFF: begin
                // Both coordinates are ready; publish them together with done.
                if (mul_done_s) begin
                    out_ld_s   = 1'b1;
                    out_x_s    = xa_r;
                    out_y_s    = mul_res_s;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_YAFF;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand and loop registers: captured inputs, accumulator, tail temporaries, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= 256'd0;
            y_r   <= 256'd0;
            z_r   <= 256'd0;
            acc_r <= 256'd0;
            t_r   <= 256'd0;
            xa_r  <= 256'd0;
            bit_r <= 8'd0;
        end else begin
            if (latch_s) begin
                x_r <= bus.x_in;
                y_r <= bus.y_in;
                z_r <= bus.z_in;
            end
            if (acc_ld_s) begin
                acc_r <= acc_nx_s;
            end
            if (bit_ld_s) begin
                bit_r <= bit_nx_s;
            end
            if (t_ld_s) begin
                t_r <= mul_res_s;
            end
            if (xa_ld_s) begin
                xa_r <= mul_res_s;
            end
        end
    end

    // Multiplier request: start is registered one cycle after the issuing decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start_r <= 1'b0;
            mul_a_r     <= 256'd0;
            mul_b_r     <= 256'd0;
        end else begin
            mul_start_r <= issue_s;
            if (issue_s) begin
                mul_a_r <= op_a_s;
                mul_b_r <= op_b_s;
            end
        end
    end

    // Registered status and result outputs; results only change alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            inf_r   <= 1'b0;
            x_out_r <= 256'd0;
            y_out_r <= 256'd0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_DONE);
            if (out_ld_s) begin
                x_out_r <= out_x_s;
                y_out_r <= out_y_s;
                inf_r   <= out_inf_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.infinity = inf_r;
    assign bus.x_out    = x_out_r;
    assign bus.y_out    = y_out_r;

endmodule

// File: tb/tb_secp256k1_jacobian_to_affine.sv
// Bench for the Jacobian-to-affine converter: directed vectors, a field-arithmetic
// reference (binary extended-Euclid inversion) and a per-cycle output comparator.
`timescale 1ns/1ps
module tb_secp256k1_jacobian_to_affine;

    localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
    localparam int MUL_L   = 2;
    localparam int N_TRANS = 507;
    localparam int LAT_FULL = N_TRANS * (MUL_L + 1) + 2;
    localparam int LAT_INF  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passes = 0;

    secp256k1_jacobian_to_affine_if bus();

    secp256k1_jacobian_to_affine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state, owned by the compare process.
    logic         model_pend = 1'b0;
    int           model_cnt = 0;
    int           model_tgt = 0;
    logic [255:0] exp_x = 256'd0, exp_y = 256'd0, hold_x = 256'd0, hold_y = 256'd0;
    logic         exp_inf = 1'b0, hold_inf = 1'b0;
    int           mul_cnt = 0, mul_exp = 0, dn_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] pr;
        pr = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
        return pr[255:0];
    endfunction

    function automatic logic [255:0] addmod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] submod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, P} - {1'b0, b});
        return s[255:0];
    endfunction

    // Binary extended-Euclid inverse mod p (independent of exponentiation).
    function automatic logic [255:0] invmod(input logic [255:0] a);
        logic [256:0] u, v, x1, x2;
        if (a == 256'd0) return 256'd0;
        u = {1'b0, a}; v = {1'b0, P}; x1 = 257'd1; x2 = 257'd0;
        for (int n = 0; n < 4000 && u != 257'd1 && v != 257'd1; n++) begin
            while (u[0] == 1'b0) begin
                u = u >> 1;
                x1 = x1[0] ? ((x1 + {1'b0, P}) >> 1) : (x1 >> 1);
            end
            while (v[0] == 1'b0) begin
                v = v >> 1;
                x2 = x2[0] ? ((x2 + {1'b0, P}) >> 1) : (x2 >> 1);
            end
            if (u >= v) begin
                u = u - v;
                x1 = (x1 >= x2) ? (x1 - x2) : (x1 + {1'b0, P} - x2);
            end else begin
                v = v - u;
                x2 = (x2 >= x1) ? (x2 - x1) : (x2 + {1'b0, P} - x1);
            end
        end
        return (u == 257'd1) ? x1[255:0] : x2[255:0];
    endfunction

    // Per-cycle comparator with the reference model of the conversion.
    initial begin : compare_proc
        logic eb, ed;
        logic [255:0] zi, zi2;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_pend = 1'b0; model_cnt = 0;
                hold_x = 256'd0; hold_y = 256'd0; hold_inf = 1'b0;
                eb = 1'b0; ed = 1'b0;
            end else begin
                if (model_pend) model_cnt++;
                eb = model_pend;
                ed = model_pend && (model_cnt == model_tgt);
                if (dut.mul_start_r) mul_cnt++;
            end
            chk("busy", 256'(bus.busy), 256'(eb));
            chk("done", 256'(bus.done), 256'(ed));
            chk("x_out", bus.x_out, ed ? exp_x : hold_x);
            chk("y_out", bus.y_out, ed ? exp_y : hold_y);
            chk("infinity", 256'(bus.infinity), 256'(ed ? exp_inf : hold_inf));
            if (bus.done) dn_cnt++;
            if (ed) begin
                hold_x = exp_x; hold_y = exp_y; hold_inf = exp_inf;
                model_pend = 1'b0;
                chk("mul_start_count", 256'(mul_cnt), 256'(mul_exp));
            end
            if (rst_n && !eb && bus.start) begin
                model_pend = 1'b1; model_cnt = 0; mul_cnt = 0;
                if (bus.z_in == 256'd0) begin
                    exp_x = 256'd0; exp_y = 256'd0; exp_inf = 1'b1;
                    mul_exp = 0; model_tgt = LAT_INF;
                end else begin
                    zi = invmod(bus.z_in);
                    zi2 = mulmod(zi, zi);
                    exp_x = mulmod(bus.x_in, zi2);
                    exp_y = mulmod(bus.y_in, mulmod(zi2, zi));
                    exp_inf = 1'b0;
                    mul_exp = N_TRANS; model_tgt = LAT_FULL;
                end
            end
        end
    end

    task automatic start_conv(input logic [255:0] xi, input logic [255:0] yi, input logic [255:0] zi);
        @(posedge clk); #1;
        bus.x_in = xi; bus.y_in = yi; bus.z_in = zi; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.x_in = 256'd3; bus.y_in = 256'd7; bus.z_in = 256'd0;
    endtask

    task automatic wait_done(input string nm, output int n);
        logic got;
        got = 1'b0; n = 0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (bus.done) got = 1'b1;
        end
        #1;
        chk({nm, "_done_seen"}, 256'(got), 256'd1);
    endtask

    task automatic wait_mul(input string nm, input int k);
        for (int n = 0; n < 3000 && mul_cnt < k; n++) @(negedge clk);
        #1;
        chk({nm, "_reached"}, 256'(mul_cnt >= k), 256'd1);
    endtask

    task automatic check_result(input string nm, input logic [255:0] ex, input logic [255:0] ey, input logic einf);
        chk({nm, "_x"}, bus.x_out, ex);
        chk({nm, "_y"}, bus.y_out, ey);
        chk({nm, "_inf"}, 256'(bus.infinity), 256'(einf));
        chk({nm, "_model_x"}, exp_x, ex);
        chk({nm, "_model_y"}, exp_y, ey);
    endtask

    initial begin : stim
        int n, d0;
        logic [255:0] yy, s, m, x3, y3, z3;
        bus.start = 1'b0; bus.x_in = 256'd0; bus.y_in = 256'd0; bus.z_in = 256'd0;
        repeat (3) @(negedge clk);
        chk("rst_x", bus.x_out, 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // G with Z = 1
        start_conv(GX, GY, 256'd1);
        wait_done("g_z1", n);
        chk("g_z1_latency", 256'(n), 256'd1523);
        chk("g_z1_muls", 256'(mul_cnt), 256'd507);
        check_result("g_z1", GX, GY, 1'b0);

        // G scaled by Z = 2
        start_conv(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2);
        wait_done("g_z2", n);
        check_result("g_z2", GX, GY, 1'b0);

        // Jacobian doubling of (Gx, Gy, 1), a = 0 curve
        yy = mulmod(GY, GY);
        s  = mulmod(256'd4, mulmod(GX, yy));
        m  = mulmod(256'd3, mulmod(GX, GX));
        x3 = submod(mulmod(m, m), addmod(s, s));
        y3 = submod(mulmod(m, submod(s, x3)), mulmod(256'd8, mulmod(yy, yy)));
        z3 = mulmod(256'd2, GY);
        start_conv(x3, y3, z3);
        wait_done("dbl", n);
        check_result("dbl", G2X, G2Y, 1'b0);

        // Z = 0: point at infinity
        start_conv(GX, GY, 256'd0);
        wait_done("inf", n);
        chk("inf_latency", 256'(n), 256'd2);
        chk("inf_muls", 256'(mul_cnt), 256'd0);
        check_result("inf", 256'd0, 256'd0, 1'b1);

        // start while busy is ignored
        d0 = dn_cnt;
        start_conv(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2);
        wait_mul("busy100", 100);
        start_conv(G2X, G2Y, 256'd1);
        wait_done("busy", n);
        check_result("busy", GX, GY, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        chk("busy_single_done", 256'(dn_cnt - d0), 256'd1);

        // reset in the middle of the inversion loop
        start_conv(GX, GY, 256'd1);
        wait_mul("rst250", 250);
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_x", bus.x_out, 256'd0);
        chk("midrst_y", bus.y_out, 256'd0);
        chk("midrst_busy", 256'(bus.busy), 256'd0);
        d0 = dn_cnt;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_done", 256'(dn_cnt - d0), 256'd0);
        start_conv(GX, GY, 256'd1);
        wait_done("after_rst", n);
        check_result("after_rst", GX, GY, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
